dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dsp_core_pkg.sv | 29 ++
 rtl/rr_pick2.sv | 70 +++++++
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_core_pkg
//  Description : Shared types and default sizing for the data-memory arbiter.
//                grant_t classifies what a memory port does in a cycle.
//                grant_type() maps (port used, write enable) to a grant_t.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsp_core_pkg;

    localparam int c_DEF_NREQ = 4;
    localparam int c_DEF_AW   = 10;
    localparam int c_DEF_DW   = 32;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_t;

    function automatic grant_t grant_type(input logic used, input logic we);
        if (!used) begin
            return GNT_NONE;
        end
        return we ? GNT_WRITE : GNT_READ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Two-winner round-robin scan. Starting at ptr, the first
//                valid requester becomes winner A and the next acceptable one
//                becomes winner B.
//  Config      : DMEM_ARB_WCONFLICT_EN - when defined, a candidate that would
//                write the same address as a writing winner A is skipped for
//                B, and the scan moves on to later requesters.
//  Ports       : valid/we/addr - per-requester request, type, address (flat)
//                ptr           - scan start position
//                found_a/idx_a - first winner
//                found_b/idx_b - second winner
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 import dsp_core_pkg::*; #(
    parameter  int NREQ = c_DEF_NREQ,
    parameter  int AW   = c_DEF_AW,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]    valid,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [IW-1:0]      ptr,
    output logic               found_a,
    output logic [IW-1:0]      idx_a,
    output logic               found_b,
    output logic [IW-1:0]      idx_b
);

    int   w_pos;
    logic w_clash;

`ifndef DMEM_ARB_WCONFLICT_EN
    // Type and address only matter to the write-conflict check.
    logic w_unused;
    assign w_unused = ^{we, addr};
`endif

    always_comb begin
        found_a = 1'b0;
        idx_a   = '0;
        found_b = 1'b0;
        idx_b   = '0;
        w_pos   = 0;
        w_clash = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            // Rotated position, wrapped without a modulo operator.
            w_pos = int'(ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
`ifdef DMEM_ARB_WCONFLICT_EN
            w_clash = found_a && we[idx_a] && we[w_pos] &&
                      (addr[int'(idx_a)*AW +: AW] == addr[w_pos*AW +: AW]);
`endif
            if (valid[w_pos]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = IW'(w_pos);
                end else if (!found_b && !w_clash) begin
                    found_b = 1'b1;
                    idx_b   = IW'(w_pos);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Arbitrates NREQ requesters onto a dual-port data memory.
//                Up to two accesses are granted per cycle in round-robin
//                order; the first winner uses port A, the second port B.
//                Reads are registered: rsp_valid[i] rises one cycle after
//                requester i's read is accepted.
//  Config      : DMEM_ARB_WCONFLICT_EN - refuse a second same-address write
//                in one cycle (default build: both are granted, port B's
//                data is what the memory keeps).
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                req_valid/we/addr/wdata - requester side (flattened buses)
//                req_ready         - combinational grant
//                rsp_valid         - read response strobe per requester
//                rsp_rdata/_b      - port A / port B read data
//                addr/wdata/we_a, rdata_a - memory port A
//                addr/wdata/we_b, rdata_b - memory port B
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter import dsp_core_pkg::*; #(
    parameter  int NREQ = c_DEF_NREQ,
    parameter  int AW   = c_DEF_AW,
    parameter  int DW   = c_DEF_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic [DW-1:0]      rsp_rdata_b,
    output logic [AW-1:0]      addr_a,
    output logic [DW-1:0]      wdata_a,
    output logic               we_a,
    input  logic [DW-1:0]      rdata_a,
    output logic [AW-1:0]      addr_b,
    output logic [DW-1:0]      wdata_b,
    output logic               we_b,
    input  logic [DW-1:0]      rdata_b
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_ptr_next;
    logic [IW-1:0]   w_last;
    logic            w_found_a;
    logic            w_found_b;
    logic [IW-1:0]   w_idx_a;
    logic [IW-1:0]   w_idx_b;
    logic            w_gnt_a;
    logic            w_gnt_b;
    grant_t          w_type_a;
    grant_t          w_type_b;
    logic            w_rd_a;
    logic            w_rd_b;
    logic [NREQ-1:0] w_rsp_set;
    logic [NREQ-1:0] r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;
    logic [DW-1:0]   r_rsp_rdata_b;

    rr_pick2 #(
        .NREQ (NREQ),
        .AW   (AW)
    ) u_pick (
        .valid   (req_valid),
        .we      (req_we),
        .addr    (req_addr),
        .ptr     (r_rr_ptr),
        .found_a (w_found_a),
        .idx_a   (w_idx_a),
        .found_b (w_found_b),
        .idx_b   (w_idx_b)
    );

    // Reset blocks every grant so nothing reaches memory or the response path.
    assign w_gnt_a = w_found_a & ~rst;
    assign w_gnt_b = w_found_b & ~rst;

    assign w_type_a = grant_type(w_gnt_a, req_we[w_idx_a]);
    assign w_type_b = grant_type(w_gnt_b, req_we[w_idx_b]);
    assign w_rd_a   = (w_type_a == GNT_READ);
    assign w_rd_b   = (w_type_b == GNT_READ);

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = (w_gnt_a && (w_idx_a == IW'(gi))) ||
                                   (w_gnt_b && (w_idx_b == IW'(gi)));
        end
    endgenerate

    // Idle ports present address/data 0 and no write.
    assign addr_a  = w_gnt_a ? req_addr[w_idx_a*AW +: AW]  : '0;
    assign wdata_a = w_gnt_a ? req_wdata[w_idx_a*DW +: DW] : '0;
    assign we_a    = (w_type_a == GNT_WRITE);
    assign addr_b  = w_gnt_b ? req_addr[w_idx_b*AW +: AW]  : '0;
    assign wdata_b = w_gnt_b ? req_wdata[w_idx_b*DW +: DW] : '0;
    assign we_b    = (w_type_b == GNT_WRITE);

    always_comb begin
        w_rsp_set = '0;
        if (w_rd_a) begin
            w_rsp_set[w_idx_a] = 1'b1;
        end
        if (w_rd_b) begin
            w_rsp_set[w_idx_b] = 1'b1;
        end
    end

    // Next scan starts just after the last winner of this cycle.
    assign w_last     = w_gnt_b ? w_idx_b : w_idx_a;
    assign w_ptr_next = (w_last == IW'(NREQ - 1)) ? '0 : w_last + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_rsp_valid   <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_rdata_b <= '0;
        end else begin
            if (w_gnt_a) begin
                r_rr_ptr <= w_ptr_next;
            end
            r_rsp_valid <= w_rsp_set;
            // The memory reads before it writes, so a same-cycle write to
            // the read address is not visible here.
            if (w_rd_a) begin
                r_rsp_rdata <= rdata_a;
            end
            if (w_rd_b) begin
                r_rsp_rdata_b <= rdata_b;
            end
        end
    end

    // A response registered just before reset is dropped as soon as rst rises.
    assign rsp_valid   = rst ? '0 : r_rsp_valid;
    assign rsp_rdata   = rst ? '0 : r_rsp_rdata;
    assign rsp_rdata_b = rst ? '0 : r_rsp_rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a dual-port
//                memory model, a reference arbiter model and a response
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
`ifdef DMEM_ARB_WCONFLICT_EN
    localparam bit WCONF = 1'b1;
`else
    localparam bit WCONF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic [DW-1:0]      rsp_rdata_b;
    logic [AW-1:0]      addr_a;
    logic [DW-1:0]      wdata_a;
    logic               we_a;
    logic [DW-1:0]      rdata_a;
    logic [AW-1:0]      addr_b;
    logic [DW-1:0]      wdata_b;
    logic               we_b;
    logic [DW-1:0]      rdata_b;

    always #5 clk = ~clk;

    dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_rdata_b (rsp_rdata_b),
        .addr_a      (addr_a),
        .wdata_a     (wdata_a),
        .we_a        (we_a),
        .rdata_a     (rdata_a),
        .addr_b      (addr_b),
        .wdata_b     (wdata_b),
        .we_b        (we_b),
        .rdata_b     (rdata_b)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return 32'hDEADBEEF;
        if (i == 16 || i == 1023) return '0;
        return DW'(i) * 32'h9E3779B1 + 32'h1234;
    endfunction

    // Dual-port memory: combinational read, write on the clock, B written last.
    logic [DW-1:0] mem [DEPTH];
    logic          mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else begin
            if (we_a) mem[addr_a] <= wdata_a;
            if (we_b) mem[addr_b] <= wdata_b;
        end
    end
    assign rdata_a = mem[addr_a];
    assign rdata_b = mem[addr_b];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_ptr;

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] mask;
        logic            has_a;
        logic            has_b;
        logic [DW-1:0]   da;
        logic [DW-1:0]   db;
    } rsp_t;
    rsp_t exp_q[$];

    // Stimulus for the next cycle
    logic [NREQ-1:0] s_valid, s_we;
    logic [AW-1:0]   s_addr  [NREQ];
    logic [DW-1:0]   s_wdata [NREQ];

    task automatic idle();
        s_valid = '0;
        s_we    = '0;
        for (int i = 0; i < NREQ; i++) begin
            s_addr[i]  = '0;
            s_wdata[i] = '0;
        end
    endtask

    task automatic req(input int i, input logic w, input int a, input logic [DW-1:0] d);
        s_valid[i] = 1'b1;
        s_we[i]    = w;
        s_addr[i]  = AW'(a);
        s_wdata[i] = d;
    endtask

    // Apply one cycle of stimulus, predict the grant, check the ports and
    // queue the expected read responses.
    task automatic step(input logic r);
        int              a_i, b_i, pos;
        int              cand[$];
        logic [NREQ-1:0] exp_rdy;
        rsp_t            e;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = s_valid;
        req_we    = s_we;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = s_addr[i];
            req_wdata[i*DW +: DW] = s_wdata[i];
        end
        // Candidates in priority order, beginning at the round-robin pointer.
        cand.delete();
        if (!r) begin
            for (int k = 0; k < NREQ; k++) begin
                pos = (m_ptr + k) % NREQ;
                if (s_valid[pos]) cand.push_back(pos);
            end
        end
        a_i = -1;
        b_i = -1;
        if (cand.size() > 0) a_i = cand[0];
        for (int k = 1; k < cand.size(); k++) begin
            if (b_i < 0) begin
                if (!(WCONF && s_we[a_i] && s_we[cand[k]] && s_addr[a_i] == s_addr[cand[k]]))
                    b_i = cand[k];
            end
        end
        exp_rdy = '0;
        if (a_i >= 0) exp_rdy[a_i] = 1'b1;
        if (b_i >= 0) exp_rdy[b_i] = 1'b1;
        #1;
        chk("req_ready", req_ready, exp_rdy);
        chk("we_a", we_a, (a_i >= 0) ? s_we[a_i] : 1'b0);
        chk("we_b", we_b, (b_i >= 0) ? s_we[b_i] : 1'b0);
        chk("addr_a", addr_a, (a_i >= 0) ? s_addr[a_i] : '0);
        chk("addr_b", addr_b, (b_i >= 0) ? s_addr[b_i] : '0);
        if (r) begin
            // Any response due this cycle is discarded by the reset.
            for (int k = exp_q.size() - 1; k >= 0; k--)
                if (exp_q[k].cyc == cyc) exp_q.delete(k);
            chk("rsp_valid_in_reset", rsp_valid, '0);
            chk("rsp_rdata_in_reset", {rsp_rdata, rsp_rdata_b}, '0);
            m_ptr = 0;
        end else begin
            e.cyc   = cyc + 1;
            e.mask  = '0;
            e.has_a = 1'b0;
            e.has_b = 1'b0;
            e.da    = '0;
            e.db    = '0;
            if (a_i >= 0 && !s_we[a_i]) begin
                e.mask[a_i] = 1'b1;
                e.has_a     = 1'b1;
                e.da        = ref_mem[s_addr[a_i]];
            end
            if (b_i >= 0 && !s_we[b_i]) begin
                e.mask[b_i] = 1'b1;
                e.has_b     = 1'b1;
                e.db        = ref_mem[s_addr[b_i]];
            end
            if (e.mask != '0) exp_q.push_back(e);
            // Reads above saw the old contents; now commit writes, B last.
            if (a_i >= 0 && s_we[a_i]) ref_mem[s_addr[a_i]] = s_wdata[a_i];
            if (b_i >= 0 && s_we[b_i]) ref_mem[s_addr[b_i]] = s_wdata[b_i];
            if (a_i >= 0) m_ptr = (((b_i >= 0) ? b_i : a_i) + 1) % NREQ;
        end
    endtask

    // Response monitor
    rsp_t mon_e;
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, '0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_cycle", cyc, mon_e.cyc);
                chk("rsp_valid", rsp_valid, mon_e.mask);
                if (mon_e.has_a) chk("rsp_rdata", rsp_rdata, mon_e.da);
                if (mon_e.has_b) chk("rsp_rdata_b", rsp_rdata_b, mon_e.db);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            chk("rsp_missing", rsp_valid, mon_e.mask);
        end
    end

    initial begin
        rst       = 1'b1;
        mem_init  = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_ptr     = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        idle();
        @(posedge clk);
        #1 mem_init = 1'b0;

        // Reset with all requesters asking: nothing may be granted.
        for (int i = 0; i < NREQ; i++) req(i, 1'b1, i, 32'hFFFF_0000 + DW'(i));
        step(1'b1);
        step(1'b1);

        // All four read: 0/1 first, then 2/3.
        idle();
        for (int i = 0; i < NREQ; i++) req(i, 1'b0, 3 * i, '0);
        step(1'b0);
        step(1'b0);
        idle();
        step(1'b0);

        // Same-address writes from 0 and 1, then read back.
        req(0, 1'b1, 10'h3FF, 32'h11);
        req(1, 1'b1, 10'h3FF, 32'h22);
        step(1'b0);
        idle();
        req(1, 1'b1, 10'h3FF, 32'h22);
        step(1'b0);
        idle();
        req(0, 1'b0, 10'h3FF, '0);
        step(1'b0);
        idle();
        step(1'b0);

        // Lone requester 2 reads back to back.
        req(2, 1'b0, 10'h005, '0);
        repeat (3) step(1'b0);
        idle();
        step(1'b0);

        // Pointer at 3 with requesters 3 and 0: wrap to 0 on port B.
        req(3, 1'b0, 10'h020, '0);
        req(0, 1'b0, 10'h021, '0);
        step(1'b0);
        idle();

        // Read and write of the same address in one cycle, then read again.
        req(0, 1'b1, 10'h010, 32'h55);
        req(1, 1'b0, 10'h010, '0);
        step(1'b0);
        idle();
        req(2, 1'b0, 10'h010, '0);
        step(1'b0);

        // Reset right after a read acceptance, then restart from requester 0.
        idle();
        req(3, 1'b0, 10'h007, '0);
        step(1'b0);
        idle();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        for (int i = 0; i < NREQ; i++) req(i, 1'b0, 40 + i, '0);
        step(1'b0);

        // Random traffic over a small address window to provoke conflicts.
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 99) < 60)
                    req(i, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                                    : int'($urandom_range(0, 7)),
                        $urandom());
            end
            step($urandom_range(0, 63) == 0);
        end

        idle();
        repeat (3) step(1'b0);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
